// File: rtl/riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// riscv_decode_stage
//
// Registered RV32I decode stage between instruction fetch and register-file
// read. Each accepted {pc, instr} pair is decoded into raw fields, control
// signals and a sign-extended immediate (I, S, B, U, J formats). Unsupported
// encodings are flagged through `illegal`. When flagged, the architectural
// side effects (regWrite, memWrite, branch, jump) are suppressed.
//
// A two-entry buffer sits behind the decoder:
//   - an output register, which holds the bundle currently presented, and
//   - a skid register, which catches one extra bundle while the output stalls.
// This keeps one-per-cycle throughput and a registered in_ready.
//
// Optional feature: define DECODE_CNT_EN to add saturating handshake counters
// (cnt_total, cnt_illegal) and the CNT_W parameter. Both are absent otherwise.
//
// Parameters:
//   XLEN   PC and immediate width (immediates sign-extended to XLEN)
//   CNT_W  statistics counter width (DECODE_CNT_EN only)
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   in_valid/in_ready           upstream handshake
//   in_instr, in_pc             instruction word and its address
//   out_valid/out_ready         downstream handshake
//   out_pc                      PC of the presented instruction
//   opcode rd rs1 rs2 funct3 funct7
//                               raw instruction fields
//   imm, immSrc                 immediate and its format (000 I, 001 S,
//                               010 B, 011 J, 100 U)
//   aluControl, aluOP           ALU operation and ALU decode class
//   resultSrc                   00 ALU, 01 mem, 10 PC+4, 11 imm
//   regWrite aluSrcA aluSrcB memWrite branch jump illegal
//                               single-bit controls
//   cnt_total, cnt_illegal      handshake counters (DECODE_CNT_EN only)
// -----------------------------------------------------------------------------
module riscv_decode_stage #(
  parameter int XLEN = 32
`ifdef DECODE_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      immSrc,
  output logic [2:0]      aluControl,
  output logic [1:0]      aluOP,
  output logic [1:0]      resultSrc,
  output logic            regWrite,
  output logic            aluSrcA,
  output logic            aluSrcB,
  output logic            memWrite,
  output logic            branch,
  output logic            jump,
  output logic            illegal
`ifdef DECODE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_illegal
`endif
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  // One decoded instruction, exactly as presented on the output ports.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_src;
    logic [2:0]      alu_control;
    logic [1:0]      alu_op;
    logic [1:0]      result_src;
    logic            reg_write;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Immediate extraction: every format is sign-extended from instr[31] to
  // 32 bits first. The selected value is then widened to XLEN.
  // ---------------------------------------------------------------------------
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  bundle_t     dec;
  logic [31:0] imm_sel;
  logic        bad_op;
  logic        bad_f3;
  logic        bad_f7;
  logic        alu_f3_bad;
  logic        is_rtype;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statements can infer a latch.
    dec        = '0;
    imm_sel    = imm_i;
    bad_op     = 1'b0;
    bad_f3     = 1'b0;
    bad_f7     = 1'b0;
    is_rtype   = 1'b0;
    alu_f3_bad = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b011) ||
                 (in_instr[14:12] == 3'b101);

    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct7 = in_instr[31:25];

    case (in_instr[6:0])
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src_b  = 1'b1;
        dec.result_src = 2'b01;
        bad_f3         = (in_instr[14:12] != 3'b010);
      end
      OP_STORE: begin
        dec.imm_src   = IMM_S;
        dec.alu_src_b = 1'b1;
        dec.mem_write = 1'b1;
        bad_f3        = (in_instr[14:12] != 3'b010);
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        is_rtype      = 1'b1;
        bad_f3        = alu_f3_bad;
        bad_f7        = (in_instr[31:25] != 7'b0000000) &&
                        (in_instr[31:25] != 7'b0100000);
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.imm_src   = IMM_I;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = 2'b10;
        bad_f3        = alu_f3_bad;
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = IMM_B;
        dec.alu_op  = 2'b01;
        bad_f3      = (in_instr[14:12] != 3'b000);
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_U;
        dec.result_src = 2'b11;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase

    case (dec.alu_op)
      2'b00: dec.alu_control = ALU_ADD;
      2'b01: dec.alu_control = ALU_SUB;
      2'b10: begin
        case (in_instr[14:12])
          // funct7 bit 5 selects sub only for register-register ops; on
          // I-ALU the same bits belong to the immediate.
          3'b000:  dec.alu_control = (is_rtype && in_instr[31:25] == 7'b0100000)
                                     ? ALU_SUB : ALU_ADD;
          3'b010:  dec.alu_control = ALU_SLT;
          3'b100:  dec.alu_control = ALU_XOR;
          3'b110:  dec.alu_control = ALU_OR;
          3'b111:  dec.alu_control = ALU_AND;
          default: dec.alu_control = ALU_ADD;
        endcase
      end
      default: dec.alu_control = ALU_ADD;
    endcase

    case (dec.imm_src)
      IMM_S:   imm_sel = imm_s;
      IMM_B:   imm_sel = imm_b;
      IMM_J:   imm_sel = imm_j;
      IMM_U:   imm_sel = imm_u;
      default: imm_sel = imm_i;
    endcase
    dec.imm = XLEN'($signed(imm_sel));

    // Illegal encodings keep their fields and immediate for trap reporting,
    // but must not change architectural state.
    dec.illegal = bad_op || bad_f3 || bad_f7;
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register plus skid register
  // ---------------------------------------------------------------------------
  bundle_t out_q;
  bundle_t skid_q;
  logic    skid_full;
  logic    fire_in;
  logic    stall;

  assign fire_in = in_valid && in_ready;
  assign stall   = out_valid && !out_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register
    // samples its pre-edge value and the block order does not matter.
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (!stall) begin
        // The output slot frees up this edge. An older bundle in skid always
        // goes first, so the FIFO order is kept.
        if (skid_full) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end else if (fire_in) begin
          out_q     <= dec;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (fire_in) begin
        skid_full <= 1'b1;
      end
      // Registered ready: drop it exactly when skid holds a bundle after
      // this edge.
      in_ready <= !(stall && (skid_full || fire_in));
    end
  end

  // NOTE: the skid payload is not reset; skid_full alone says whether it is
  // meaningful, and reset clears that flag.
  always_ff @(posedge clk) begin
    if (stall && fire_in) begin
      skid_q <= dec;
    end
  end

  assign out_pc     = out_q.pc;
  assign opcode     = out_q.opcode;
  assign rd         = out_q.rd;
  assign rs1        = out_q.rs1;
  assign rs2        = out_q.rs2;
  assign funct3     = out_q.funct3;
  assign funct7     = out_q.funct7;
  assign imm        = out_q.imm;
  assign immSrc     = out_q.imm_src;
  assign aluControl = out_q.alu_control;
  assign aluOP      = out_q.alu_op;
  assign resultSrc  = out_q.result_src;
  assign regWrite   = out_q.reg_write;
  assign aluSrcA    = out_q.alu_src_a;
  assign aluSrcB    = out_q.alu_src_b;
  assign memWrite   = out_q.mem_write;
  assign branch     = out_q.branch;
  assign jump       = out_q.jump;
  assign illegal    = out_q.illegal;

`ifdef DECODE_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating handshake statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_total   <= '0;
      cnt_illegal <= '0;
    end else if (out_valid && out_ready) begin
      if (cnt_total != '1) begin
        cnt_total <= cnt_total + CNT_W'(1);
      end
      if (out_q.illegal && (cnt_illegal != '1)) begin
        cnt_illegal <= cnt_illegal + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_riscv_decode_stage
//
// Directed-vector bench for riscv_decode_stage. Every expected bundle is
// written out by hand. The stimulus process pushes an expected bundle into a
// queue when its instruction is accepted. An independent monitor pops that
// queue on every output handshake and compares field groups. Inline checks
// cover reset, latency, stall hold and drain timing.
// -----------------------------------------------------------------------------
module tb_riscv_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  imm_src;
    logic [2:0]  alu_control;
    logic [1:0]  alu_op;
    logic [1:0]  result_src;
    logic [6:0]  flags;  // {regWrite, aluSrcA, aluSrcB, memWrite, branch, jump, illegal}
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  immSrc, aluControl;
  logic [1:0]  aluOP, resultSrc;
  logic        regWrite, aluSrcA, aluSrcB, memWrite, branch, jump, illegal;
`ifdef DECODE_CNT_EN
  logic [15:0] cnt_total, cnt_illegal;
`endif

  riscv_decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .immSrc     (immSrc),
    .aluControl (aluControl),
    .aluOP      (aluOP),
    .resultSrc  (resultSrc),
    .regWrite   (regWrite),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .memWrite   (memWrite),
    .branch     (branch),
    .jump       (jump),
    .illegal    (illegal)
`ifdef DECODE_CNT_EN
    ,
    .cnt_total  (cnt_total),
    .cnt_illegal(cnt_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   hs_total   = 0;
  int   hs_illegal = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] op,
                              input logic [4:0] f_rd, input logic [4:0] f_rs1,
                              input logic [4:0] f_rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im,
                              input logic [2:0] isrc, input logic [2:0] actl,
                              input logic [1:0] aop, input logic [1:0] rsrc,
                              input logic [6:0] flg);
    exp_t e;
    e.pc = pc; e.opcode = op; e.rd = f_rd; e.rs1 = f_rs1; e.rs2 = f_rs2;
    e.funct3 = f3; e.funct7 = f7; e.imm = im; e.imm_src = isrc;
    e.alu_control = actl; e.alu_op = aop; e.result_src = rsrc; e.flags = flg;
    return e;
  endfunction

  function automatic exp_t capture();
    exp_t a;
    a.pc = out_pc; a.opcode = opcode; a.rd = rd; a.rs1 = rs1; a.rs2 = rs2;
    a.funct3 = funct3; a.funct7 = funct7; a.imm = imm; a.imm_src = immSrc;
    a.alu_control = aluControl; a.alu_op = aluOP; a.result_src = resultSrc;
    a.flags = {regWrite, aluSrcA, aluSrcB, memWrite, branch, jump, illegal};
    return a;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] instr, input exp_t e);
    int g = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = e.pc;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (in_ready) sb.push_back(e);
    else check("accept_timeout", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: pops and compares on every output handshake.
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hs_total   = 0;
        hs_illegal = 0;
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", 128'(out_valid), 128'(0));
        end else begin
          e = sb.pop_front();
          a = capture();
          check($sformatf("pc_%0h", e.pc), 128'(a.pc), 128'(e.pc));
          check($sformatf("fields_%0h", e.pc),
                128'({a.opcode, a.rd, a.rs1, a.rs2, a.funct3, a.funct7}),
                128'({e.opcode, e.rd, e.rs1, e.rs2, e.funct3, e.funct7}));
          check($sformatf("imm_%0h", e.pc), 128'(a.imm), 128'(e.imm));
          check($sformatf("ctrl_%0h", e.pc),
                128'({a.imm_src, a.alu_control, a.alu_op, a.result_src, a.flags}),
                128'({e.imm_src, e.alu_control, e.alu_op, e.result_src, e.flags}));
`ifdef DECODE_CNT_EN
          check("cnt_total", 128'(cnt_total), 128'(hs_total));
          check("cnt_illegal", 128'(cnt_illegal), 128'(hs_illegal));
`endif
          hs_total++;
          if (e.flags[0]) hs_illegal++;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int g = 0;
    while (!in_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    check(name, 128'(in_ready), 128'(1));
  endtask

  initial begin : stimulus
    exp_t ea, eb, ec;
    int g;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_bundle", 128'(capture()), 128'(0));
`ifdef DECODE_CNT_EN
    check("rst_cnt", 128'({cnt_total, cnt_illegal}), 128'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    wait_ready("in_ready_after_rst");

    // addi x2, x0, 5
    send(32'h00500113, mk(32'h100, 7'h13, 5'd2, 5'd0, 5'd5, 3'd0, 7'h00, 32'd5,
                          3'd0, 3'd0, 2'd2, 2'd0, 7'b1010000));
    #1 check("latency_valid", 128'(out_valid), 128'(1));

    // addi x7, x3, -9 then or x4, x7, x2 back-to-back
    send(32'hFF718393, mk(32'h104, 7'h13, 5'd7, 5'd3, 5'd23, 3'd0, 7'h7F, 32'hFFFFFFF7,
                          3'd0, 3'd0, 2'd2, 2'd0, 7'b1010000));
    #1 check("b2b_first_valid", 128'(out_valid), 128'(1));
    send(32'h0023E233, mk(32'h108, 7'h33, 5'd4, 5'd7, 5'd2, 3'd6, 7'h00, 32'd2,
                          3'd0, 3'd3, 2'd2, 2'd0, 7'b1000000));
    #1 check("b2b_no_bubble", 128'(out_valid), 128'(1));

    // beq, sw, jal
    send(32'h02728863, mk(32'h10C, 7'h63, 5'd16, 5'd5, 5'd7, 3'd0, 7'h01, 32'd48,
                          3'd2, 3'd1, 2'd1, 2'd0, 7'b0000100));
    send(32'h0471AA23, mk(32'h110, 7'h23, 5'd20, 5'd3, 5'd7, 3'd2, 7'h02, 32'd84,
                          3'd1, 3'd0, 2'd0, 2'd0, 7'b0011000));
    send(32'h008001EF, mk(32'h114, 7'h6F, 5'd3, 5'd0, 5'd8, 3'd0, 7'h00, 32'd8,
                          3'd3, 3'd0, 2'd0, 2'd2, 7'b1000010));
    // sub, lui, lw (negative), auipc, beq backward (negative B)
    send(32'h40B50533, mk(32'h118, 7'h33, 5'd10, 5'd10, 5'd11, 3'd0, 7'h20, 32'd1035,
                          3'd0, 3'd1, 2'd2, 2'd0, 7'b1000000));
    send(32'h123452B7, mk(32'h11C, 7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000,
                          3'd4, 3'd0, 2'd0, 2'd3, 7'b1000000));
    send(32'hFFC12303, mk(32'h120, 7'h03, 5'd6, 5'd2, 5'd28, 3'd2, 7'h7F, 32'hFFFFFFFC,
                          3'd0, 3'd0, 2'd0, 2'd1, 7'b1010000));
    send(32'h00001097, mk(32'h124, 7'h17, 5'd1, 5'd0, 5'd0, 3'd1, 7'h00, 32'h00001000,
                          3'd4, 3'd0, 2'd0, 2'd0, 7'b1110000));
    send(32'hFE000EE3, mk(32'h128, 7'h63, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFFFFFC,
                          3'd2, 3'd1, 2'd1, 2'd0, 7'b0000100));

    // Illegal: zero word, R-type funct3 101, bne, R-type funct7 0000001
    send(32'h00000000, mk(32'h12C, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,
                          3'd0, 3'd0, 2'd0, 2'd0, 7'b0000001));
    send(32'h0041D233, mk(32'h130, 7'h33, 5'd4, 5'd3, 5'd4, 3'd5, 7'h00, 32'd4,
                          3'd0, 3'd0, 2'd2, 2'd0, 7'b0000001));
    send(32'h00001463, mk(32'h134, 7'h63, 5'd8, 5'd0, 5'd0, 3'd1, 7'h00, 32'd8,
                          3'd2, 3'd1, 2'd1, 2'd0, 7'b0000001));
    send(32'h02B50533, mk(32'h138, 7'h33, 5'd10, 5'd10, 5'd11, 3'd0, 7'h01, 32'd43,
                          3'd0, 3'd0, 2'd2, 2'd0, 7'b0000001));
    repeat (2) @(negedge clk);

    // Stall: three instructions with out_ready low, then release
    ea = mk(32'h200, 7'h13, 5'd2, 5'd0, 5'd5, 3'd0, 7'h00, 32'd5,
            3'd0, 3'd0, 2'd2, 2'd0, 7'b1010000);
    eb = mk(32'h204, 7'h33, 5'd4, 5'd7, 5'd2, 3'd6, 7'h00, 32'd2,
            3'd0, 3'd3, 2'd2, 2'd0, 7'b1000000);
    ec = mk(32'h208, 7'h23, 5'd20, 5'd3, 5'd7, 3'd2, 7'h02, 32'd84,
            3'd1, 3'd0, 2'd0, 2'd0, 7'b0011000);
    out_ready = 1'b0;
    send(32'h00500113, ea);
    send(32'h0023E233, eb);
    #1;
    check("stall_in_ready_low", 128'(in_ready), 128'(0));
    check("stall_hold_first", 128'(capture()), 128'(ea));
    fork
      send(32'h0471AA23, ec);
      begin
        repeat (2) begin
          @(negedge clk);
          #1;
          check("stall_hold", 128'({out_valid, capture()}), 128'({1'b1, ea}));
          check("stall_in_ready", 128'(in_ready), 128'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1 check("drain_second", 128'({out_valid, out_pc}), 128'({1'b1, 32'h204}));
        @(negedge clk);
        #1 check("drain_third", 128'({out_valid, out_pc}), 128'({1'b1, 32'h208}));
      end
    join
    repeat (2) @(negedge clk);

    // Reset during a stall with skid full
    out_ready = 1'b0;
    send(32'h008001EF, mk(32'h300, 7'h6F, 5'd3, 5'd0, 5'd8, 3'd0, 7'h00, 32'd8,
                          3'd3, 3'd0, 2'd0, 2'd2, 7'b1000010));
    send(32'h00000000, mk(32'h304, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,
                          3'd0, 3'd0, 2'd0, 2'd0, 7'b0000001));
    #1 check("pre_rst_skid_full", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_bundle", 128'(capture()), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
`ifdef DECODE_CNT_EN
    check("mid_rst_cnt", 128'({cnt_total, cnt_illegal}), 128'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_ready("in_ready_after_mid_rst");
    repeat (4) begin
      @(negedge clk);
      #1 check("no_stale_bundle", 128'(out_valid), 128'(0));
    end

    // One more instruction after reset to confirm normal operation resumed
    send(32'hFF718393, mk(32'h400, 7'h13, 5'd7, 5'd3, 5'd23, 3'd0, 7'h7F, 32'hFFFFFFF7,
                          3'd0, 3'd0, 2'd2, 2'd0, 7'b1010000));
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
